// File: rtl/arbiter.sv
// arbiter: round-robin packet arbiter for a NoC router input stage.
// Each cycle one valid packet (bit 0 set) is picked from REN input buffers
// and registered onto output_data. Its index is registered onto shift so the
// upstream buffer can pop that entry. 4'hF on shift means "no grant".
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
// In that mode the round-robin pointer does not exist.
// Handshake: none. valid == packet bit 0. The consumer must drop entry
// `shift` before the next edge, or that entry competes again as a fresh request.

`ifndef PL
`define PL 8
`endif
`ifndef REN
`define REN 5
`endif

module arbiter #(
   parameter int PL  = `PL,   // packet width, bit 0 is the valid flag
   parameter int REN = `REN   // requesters, 2..15 so 4'hF stays free as "idle"
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [0:PL-1] input_ [0:REN-1],
   output logic [0:PL-1] output_data,
   output logic [3:0]    shift
);

   logic [REN-1:0] w_req;
   logic           w_found;
   logic [3:0]     w_win;
   logic [0:PL-1]  w_data;

   // Request vector: the valid flag of every candidate packet.
   always_comb begin
      w_req = '0;
      for (int i = 0; i < REN; i++) begin
         w_req[i] = input_[i][0];
      end
   end

`ifdef ARB_FIXED_PRIO_EN
   // Fixed priority: the lowest-index requester wins. The loop descends, so
   // the last assignment made is the lowest index.
   always_comb begin
      w_found = 1'b0;
      w_win   = 4'hF;
      for (int i = REN - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_found = 1'b1;
            w_win   = 4'(i);
         end
      end
   end
`else
   logic [3:0] r_rr_ptr;
   logic       w_hi_found;
   logic       w_lo_found;
   logic [3:0] w_hi_idx;
   logic [3:0] w_lo_idx;
   logic [3:0] w_next_ptr;

   // Round-robin search, split into two ranges. The "hi" range is
   // rr_ptr..REN-1 and the "lo" range is 0..rr_ptr-1. The lowest hit in hi
   // wins; otherwise the lowest hit in lo wins. This matches a wrapping scan
   // that starts at rr_ptr, and it avoids any variable-width array index.
   always_comb begin
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi_idx   = 4'h0;
      w_lo_idx   = 4'h0;
      for (int i = REN - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            if (i >= int'(r_rr_ptr)) begin
               w_hi_found = 1'b1;
               w_hi_idx   = 4'(i);
            end else begin
               w_lo_found = 1'b1;
               w_lo_idx   = 4'(i);
            end
         end
      end
      w_found    = w_hi_found | w_lo_found;
      w_win      = w_hi_found ? w_hi_idx : (w_lo_found ? w_lo_idx : 4'hF);
      w_next_ptr = (w_win == 4'(REN - 1)) ? 4'h0 : w_win + 4'h1;
   end
`endif

   // Packet mux: select the winning packet. With no winner the result is
   // all-zero, so an idle cycle never replays an old packet.
   always_comb begin
      w_data = '0;
      for (int i = 0; i < REN; i++) begin
         if (w_found && (w_win == 4'(i))) begin
            w_data = input_[i];
         end
      end
   end

   // Output and pointer registers. Reset drops any grant that is in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         output_data <= '0;
         shift       <= 4'hF;
`ifndef ARB_FIXED_PRIO_EN
         r_rr_ptr    <= 4'h0;
`endif
      end else if (w_found) begin
         output_data <= w_data;
         shift       <= w_win;
`ifndef ARB_FIXED_PRIO_EN
         r_rr_ptr    <= w_next_ptr;
`endif
      end else begin
         output_data <= '0;
         shift       <= 4'hF;
      end
   end

endmodule

// File: tb/tb_arbiter.sv
// tb_arbiter: directed bench for the arbiter. Vectors are hand-computed for
// PL=8, REN=5. Expectations follow ARB_FIXED_PRIO_EN when it is defined.

`timescale 1ns/1ps

module tb_arbiter;

   logic       clk;
   logic       rst_n;
   logic [0:7] in_pkts [0:4];
   logic [0:7] output_data;
   logic [3:0] shift;

   int n_vec;
   int n_err;

   arbiter #(.PL(8), .REN(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_      (in_pkts),
      .output_data (output_data),
      .shift       (shift)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inputs(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d,
                             input logic [7:0] e);
      in_pkts[0] = a;
      in_pkts[1] = b;
      in_pkts[2] = c;
      in_pkts[3] = d;
      in_pkts[4] = e;
   endtask

   // Scenario tasks
   task automatic test_reset();
      rst_n = 1'b0;
      set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      step();
      n_vec++;
      if (output_data !== 8'h00 || shift !== 4'hF) begin
         n_err++;
         $display("FAIL reset: got data=%h shift=%h expected data=00 shift=f", output_data, shift);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_vec++;
         if (output_data !== 8'h00 || shift !== 4'hF) begin
            n_err++;
            $display("FAIL idle_hold cycle %0d: got data=%h shift=%h expected data=00 shift=f", c, output_data, shift);
         end
      end
   endtask

   task automatic test_two_requesters();
      logic [7:0] exp_d [2];
      logic [3:0] exp_s [2];
`ifdef ARB_FIXED_PRIO_EN
      exp_d = '{8'hFF, 8'hFF};
      exp_s = '{4'h0, 4'h0};
`else
      exp_d = '{8'hFF, 8'hAA};
      exp_s = '{4'h0, 4'h2};
`endif
      set_inputs(8'hFF, 8'h00, 8'hAA, 8'h00, 8'h00);
      for (int c = 0; c < 2; c++) begin
         step();
         n_vec++;
         if (output_data !== exp_d[c] || shift !== exp_s[c]) begin
            n_err++;
            $display("FAIL two_req cycle %0d: got data=%h shift=%h expected data=%h shift=%h", c, output_data, shift, exp_d[c], exp_s[c]);
         end
      end
   endtask

   task automatic test_drain();
      in_pkts[0] = 8'h00;
      step();
      n_vec++;
      if (output_data !== 8'hAA || shift !== 4'h2) begin
         n_err++;
         $display("FAIL drain_aa: got data=%h shift=%h expected data=aa shift=2", output_data, shift);
      end
      in_pkts[2] = 8'h00;
      for (int c = 0; c < 2; c++) begin
         step();
         n_vec++;
         if (output_data !== 8'h00 || shift !== 4'hF) begin
            n_err++;
            $display("FAIL drain_empty cycle %0d: got data=%h shift=%h expected data=00 shift=f", c, output_data, shift);
         end
      end
   endtask

   // The pointer sits at 3 here. Only 0x80 has bit 0 set.
   task automatic test_valid_filter();
      set_inputs(8'h10, 8'h20, 8'h80, 8'h40, 8'h50);
      step();
      n_vec++;
      if (output_data !== 8'h80 || shift !== 4'h2) begin
         n_err++;
         $display("FAIL valid_filter: got data=%h shift=%h expected data=80 shift=2", output_data, shift);
      end
      in_pkts[2] = 8'h00;
      step();
      n_vec++;
      if (output_data !== 8'h00 || shift !== 4'hF) begin
         n_err++;
         $display("FAIL valid_filter_clear: got data=%h shift=%h expected data=00 shift=f", output_data, shift);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] exp_s [6];
`ifdef ARB_FIXED_PRIO_EN
      exp_s = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`else
      exp_s = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
`endif
      rst_n = 1'b0;
      set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      step();
      rst_n = 1'b1;
      set_inputs(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      for (int c = 0; c < 6; c++) begin
         step();
         n_vec++;
         if (output_data !== 8'hFF || shift !== exp_s[c]) begin
            n_err++;
            $display("FAIL wrap cycle %0d: got data=%h shift=%h expected data=ff shift=%h", c, output_data, shift, exp_s[c]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic [3:0] exp_s [2];
`ifdef ARB_FIXED_PRIO_EN
      exp_s = '{4'h0, 4'h0};
`else
      exp_s = '{4'h0, 4'h1};
`endif
      // All inputs are still 0xFF from the wrap test, and grants are flowing.
      rst_n = 1'b0;
      step();
      n_vec++;
      if (output_data !== 8'h00 || shift !== 4'hF) begin
         n_err++;
         $display("FAIL midreset: got data=%h shift=%h expected data=00 shift=f", output_data, shift);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         n_vec++;
         if (output_data !== 8'hFF || shift !== exp_s[c]) begin
            n_err++;
            $display("FAIL post_reset cycle %0d: got data=%h shift=%h expected data=ff shift=%h", c, output_data, shift, exp_s[c]);
         end
      end
      // An idle cycle must leave the pointer alone. It stays at 2 here.
      set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      step();
      n_vec++;
      if (output_data !== 8'h00 || shift !== 4'hF) begin
         n_err++;
         $display("FAIL idle_gap: got data=%h shift=%h expected data=00 shift=f", output_data, shift);
      end
   endtask

   // Inputs 0 and 4 both stay valid. The round-robin pointer starts at 2,
   // so grants alternate 4,0,4. Payload bits pass through unchanged.
   task automatic test_back_to_back();
      logic [7:0] exp_d [3];
      logic [3:0] exp_s [3];
`ifdef ARB_FIXED_PRIO_EN
      exp_d = '{8'h81, 8'h81, 8'h81};
      exp_s = '{4'h0, 4'h0, 4'h0};
`else
      exp_d = '{8'hC3, 8'h81, 8'hC3};
      exp_s = '{4'h4, 4'h0, 4'h4};
`endif
      set_inputs(8'h81, 8'h00, 8'h00, 8'h00, 8'hC3);
      for (int c = 0; c < 3; c++) begin
         step();
         n_vec++;
         if (output_data !== exp_d[c] || shift !== exp_s[c]) begin
            n_err++;
            $display("FAIL back_to_back cycle %0d: got data=%h shift=%h expected data=%h shift=%h", c, output_data, shift, exp_d[c], exp_s[c]);
         end
      end
   endtask

   // Sequence and final report
   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      test_reset();
      test_two_requesters();
      test_drain();
      test_valid_filter();
      test_wrap();
      test_reset_midstream();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
